acc_cpu_core: RTL

Parametrised multi-cycle accumulator CPU core, next generation of the single-cycle 8-bit cpu top. Generalises data width, register-file depth, PC and data-address widths. Adds valid/ready handshakes to external program and data memories, an internal register file, zero/carry flags, conditional branches and HALT. Instantiated in the SoC top between the instruction ROM and the data RAM wrappers.

---
 rtl/acc_cpu_pkg.sv | 44 ++++
 rtl/acc_cpu_if.sv | 36 +++
 rtl/acc_alu_p.sv | 54 +++++
 rtl/acc_cpu_core.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared types and constants for the multi-cycle accumulator CPU core.
package acc_cpu_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_W   = 8;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_NOT  = 4'h6,
      OP_LDI  = 4'h7,
      OP_LDA  = 4'h8,
      OP_STA  = 4'h9,
      OP_LDM  = 4'hA,
      OP_STM  = 4'hB,
      OP_JMP  = 4'hC,
      OP_JZ   = 4'hD,
      OP_JC   = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } state_e;

   // Opcodes whose EXEC cycle writes the accumulator (and therefore the flags).
   function automatic logic writes_acc(input opcode_e op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_NOT, OP_LDI, OP_LDA:  writes_acc = 1'b1;
         default:                 writes_acc = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Instruction-fetch and data-memory handshake bundle between the core and its memories.
interface acc_cpu_if
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 5,
   parameter int DADDR_W = 10
) ();

   logic                o_imem_req;
   logic [PC_W-1:0]     o_imem_addr;
   logic                i_imem_valid;
   logic [INSTR_W-1:0]  i_imem_data;

   logic                o_dmem_req;
   logic                o_dmem_we;
   logic [DADDR_W-1:0]  o_dmem_addr;
   logic [DATA_W-1:0]   o_dmem_wdata;
   logic                i_dmem_ready;
   logic [DATA_W-1:0]   i_dmem_rdata;

   modport master (
      output o_imem_req, o_imem_addr,
      input  i_imem_valid, i_imem_data,
      output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
      input  i_dmem_ready, i_dmem_rdata
   );

   modport slave (
      input  o_imem_req, o_imem_addr,
      output i_imem_valid, i_imem_data,
      input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
      output i_dmem_ready, i_dmem_rdata
   );

endinterface

// File: rtl/acc_alu_p.sv
// Combinational accumulator ALU: computes the new ACC value and carry for ALU/load ops.
module acc_alu_p
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  opcode_e             opcode,
   input  logic [DATA_W-1:0]   acc,
   input  logic [DATA_W-1:0]   operand,
   input  logic                carry_in,
   output logic [DATA_W-1:0]   result,
   output logic                carry_out
);

   logic [DATA_W:0] sum;

   // Result/carry select; loads pass the operand through and keep the carry.
   always_comb begin
      result    = acc;
      carry_out = carry_in;
      sum       = {1'b0, acc} + {1'b0, operand};
      case (opcode)
         OP_ADD: begin
            result    = sum[DATA_W-1:0];
            carry_out = sum[DATA_W];
         end
         OP_SUB: begin
            result    = acc - operand;
            carry_out = (acc < operand);
         end
         OP_AND: begin
            result    = acc & operand;
            carry_out = 1'b0;
         end
         OP_OR: begin
            result    = acc | operand;
            carry_out = 1'b0;
         end
         OP_XOR: begin
            result    = acc ^ operand;
            carry_out = 1'b0;
         end
         OP_NOT: begin
            result    = ~acc;
            carry_out = 1'b0;
         end
         OP_LDI, OP_LDA: begin
            result    = operand;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH -> EXEC [-> MEM] with handshaked program/data memories.
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NREG    = 4,
   parameter int PC_W    = 5,
   parameter int DADDR_W = 10
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_ce,
   acc_cpu_if.master           bus,
   output logic [PC_W-1:0]     o_pc,
   output logic [DATA_W-1:0]   o_acc,
   output logic                o_carry,
   output logic                o_zero,
   output logic                o_halted
);

   localparam int RIDX_W = $clog2(NREG);

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q;
   logic [DATA_W-1:0]    acc_q;
   logic                 carry_q;
   logic                 zero_q;
   logic [INSTR_W-1:0]   ir_q;
   logic [DATA_W-1:0]    regs_q [NREG];

   opcode_e              opcode;
   logic [RIDX_W-1:0]    ridx;
   logic [IMM_W-1:0]     imm;
   logic [DADDR_W-1:0]   daddr;
   logic [PC_W-1:0]      target;
   logic [DATA_W-1:0]    reg_val;
   logic [DATA_W-1:0]    alu_opnd;
   logic [DATA_W-1:0]    alu_res;
   logic                 alu_carry;
   logic                 take_jump;
   logic                 unused_ir;

   assign opcode    = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
   assign ridx      = ir_q[RIDX_W-1:0];
   assign imm       = ir_q[IMM_W-1:0];
   assign daddr     = ir_q[DADDR_W-1:0];
   assign target    = ir_q[PC_W-1:0];
   // Operand bits above each field are don't-care; folding them here marks them as deliberately ignored.
   assign unused_ir = ^ir_q;

   assign reg_val   = regs_q[ridx];
   assign alu_opnd  = (opcode == OP_LDI) ? DATA_W'(imm) : reg_val;
   assign take_jump = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && zero_q) ||
                      ((opcode == OP_JC) && carry_q);

   acc_alu_p #(.DATA_W(DATA_W)) u_alu (
      .opcode    (opcode),
      .acc       (acc_q),
      .operand   (alu_opnd),
      .carry_in  (carry_q),
      .result    (alu_res),
      .carry_out (alu_carry)
   );

   // State register; i_ce low freezes the sequencer in place.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_FETCH;
      end else if (i_ce) begin
         state_q <= state_d;
      end
   end

   // Next-state: fetch waits for valid, EXEC is a single cycle, MEM waits for ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: if (bus.i_imem_valid) state_d = ST_EXEC;
         ST_EXEC: begin
            case (opcode)
               OP_LDM, OP_STM: state_d = ST_MEM;
               OP_HALT:        state_d = ST_HALT;
               default:        state_d = ST_FETCH;
            endcase
         end
         ST_MEM:   if (bus.i_dmem_ready) state_d = ST_FETCH;
         default:  state_d = ST_HALT;
      endcase
   end

   // Architectural state: IR/PC at fetch, ACC/flags/regs/PC at EXEC, ACC/zero on load completion.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pc_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         ir_q    <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (i_ce) begin
         case (state_q)
            ST_FETCH: begin
               if (bus.i_imem_valid) begin
                  ir_q <= bus.i_imem_data;
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            ST_EXEC: begin
               if (writes_acc(opcode)) begin
                  acc_q   <= alu_res;
                  carry_q <= alu_carry;
                  zero_q  <= (alu_res == '0);
               end
               if (opcode == OP_STA) regs_q[ridx] <= acc_q;
               if (take_jump) pc_q <= target;
            end
            ST_MEM: begin
               if (bus.i_dmem_ready && (opcode == OP_LDM)) begin
                  acc_q  <= bus.i_dmem_rdata;
                  zero_q <= (bus.i_dmem_rdata == '0);
               end
            end
            default: ;
         endcase
      end
   end

   // Requests are gated by reset so an in-flight access drops without waiting for a clock.
   assign bus.o_imem_req   = i_rst && (state_q == ST_FETCH);
   assign bus.o_imem_addr  = pc_q;
   assign bus.o_dmem_req   = i_rst && (state_q == ST_MEM);
   assign bus.o_dmem_we    = i_rst && (state_q == ST_MEM) && (opcode == OP_STM);
   assign bus.o_dmem_addr  = daddr;
   assign bus.o_dmem_wdata = acc_q;

   assign o_pc     = pc_q;
   assign o_acc    = acc_q;
   assign o_carry  = carry_q;
   assign o_zero   = zero_q;
   assign o_halted = (state_q == ST_HALT);

endmodule
